// File: rtl/mem_arbiter.sv
// mem_arbiter: owns the single byte-wide RAM port and shares it between
// instruction-cache block refills and load/store data accesses.
// Multi-byte transfers are sequenced one byte per cycle; reads assemble
// little-endian into a shared block-wide register.
//
// Ports:
//   clkIn, resetIn                    clock, asynchronous active-low reset
//   ramDataIn/ramDataOut/ramAddr/ramWr   RAM port; read data valid one
//                                     cycle after its address is driven
//   icacheMiss/icacheAddr/fetchAbort  refill request, block address, flush
//   refillValid/refillAddr/refillData refill result (one-cycle pulse)
//   dataReq/dataWrite/dataAddr/dataSize/dataIn   load/store request
//   dataDone/dataOut                  access complete pulse, load result
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 17,
  parameter int BLOCK_WIDTH = 4,
  parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
) (
  input  logic                              clkIn,
  input  logic                              resetIn,
  input  logic [7:0]                        ramDataIn,
  output logic [7:0]                        ramDataOut,
  output logic [ADDR_WIDTH-1:0]             ramAddr,
  output logic                              ramWr,
  input  logic                              icacheMiss,
  input  logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] icacheAddr,
  input  logic                              fetchAbort,
  output logic                              refillValid,
  output logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] refillAddr,
  output logic [BLOCK_SIZE*8-1:0]           refillData,
  input  logic                              dataReq,
  input  logic                              dataWrite,
  input  logic [ADDR_WIDTH-1:0]             dataAddr,
  input  logic [1:0]                        dataSize,
  input  logic [31:0]                       dataIn,
  output logic                              dataDone,
  output logic [31:0]                       dataOut
);

  // Counter must reach both BLOCK_SIZE and 4 (word access).
  localparam int CNT_WIDTH  = ((BLOCK_WIDTH > 2) ? BLOCK_WIDTH : 2) + 1;
  localparam int TAG_WIDTH  = ADDR_WIDTH - BLOCK_WIDTH;
  localparam int BLOCK_BITS = BLOCK_SIZE * 8;

  typedef enum logic [1:0] {IDLE, LOAD, STORE, FETCH} arbState;

  arbState               state, stateNext;
  logic [CNT_WIDTH-1:0]  cnt, len, reqLen;
  logic [ADDR_WIDTH-1:0] base;
  logic [31:0]           storeData;
  logic [7:0]            storeByte;
  logic [TAG_WIDTH-1:0]  fetchBlock;
  logic [BLOCK_BITS-1:0] asmReg, asmNext;
  logic                  acceptData, acceptFetch, lastCycle;

  // A requester is never re-accepted while its own done pulse is high;
  // the other requester may be.
  assign acceptData  = dataReq && !dataDone;
  assign acceptFetch = icacheMiss && !fetchAbort && !refillValid;

  // Every transfer ends with one extra cycle (cnt == len) that drives no
  // RAM access: reads capture their last byte there, stores simply finish.
  assign lastCycle = (cnt == len);

  always_comb begin
    case (dataSize)
      2'b00:   reqLen = CNT_WIDTH'(1);
      2'b01:   reqLen = CNT_WIDTH'(2);
      default: reqLen = CNT_WIDTH'(4);
    endcase
  end

  // The byte read during cycle cnt belongs to address base+cnt-1.
  always_comb begin
    asmNext = asmReg;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      if (cnt == CNT_WIDTH'(i + 1)) asmNext[i*8 +: 8] = ramDataIn;
    end
  end

  assign storeByte = storeData[{cnt[1:0], 3'b000} +: 8];

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    stateNext  = state;
    ramAddr    = '0;
    ramDataOut = '0;
    ramWr      = 1'b0;
    case (state)
      IDLE: begin
        if (acceptData)       stateNext = dataWrite ? STORE : LOAD;
        else if (acceptFetch) stateNext = FETCH;
      end
      LOAD: begin
        if (lastCycle) stateNext = IDLE;
        else           ramAddr   = base + ADDR_WIDTH'(cnt);
      end
      STORE: begin
        if (lastCycle) begin
          stateNext = IDLE;
        end else begin
          ramAddr    = base + ADDR_WIDTH'(cnt);
          ramDataOut = storeByte;
          ramWr      = 1'b1;
        end
      end
      FETCH: begin
        // A flush wins even on the completion edge.
        if (fetchAbort || lastCycle) stateNext = IDLE;
        else                         ramAddr   = base + ADDR_WIDTH'(cnt);
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) state <= IDLE;
    else          state <= stateNext;
  end

  // NOTE: the block-wide assembly register is reset along with the rest;
  // it is a plain register, not a RAM, and zeroing it keeps the
  // zero-extension of short loads independent of history.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      cnt         <= '0;
      len         <= '0;
      base        <= '0;
      storeData   <= '0;
      fetchBlock  <= '0;
      asmReg      <= '0;
      refillValid <= 1'b0;
      refillAddr  <= '0;
      refillData  <= '0;
      dataDone    <= 1'b0;
      dataOut     <= '0;
    end else begin
      dataDone    <= 1'b0;
      refillValid <= 1'b0;
      case (state)
        IDLE: begin
          cnt    <= '0;
          asmReg <= '0;
          if (acceptData) begin
            base      <= dataAddr;
            len       <= reqLen;
            storeData <= dataIn;
          end else if (acceptFetch) begin
            base       <= {icacheAddr, {BLOCK_WIDTH{1'b0}}};
            len        <= CNT_WIDTH'(BLOCK_SIZE);
            fetchBlock <= icacheAddr;
          end
        end
        LOAD: begin
          cnt    <= cnt + CNT_WIDTH'(1);
          asmReg <= asmNext;
          if (lastCycle) begin
            dataOut  <= asmNext[31:0];
            dataDone <= 1'b1;
          end
        end
        STORE: begin
          cnt <= cnt + CNT_WIDTH'(1);
          if (lastCycle) dataDone <= 1'b1;
        end
        FETCH: begin
          cnt    <= cnt + CNT_WIDTH'(1);
          asmReg <= asmNext;
          if (lastCycle && !fetchAbort) begin
            refillData  <= asmNext;
            refillAddr  <= fetchBlock;
            refillValid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-wide registered-read RAM model.
module tb_mem_arbiter;

  localparam int AW = 17;
  localparam int BW = 4;
  localparam int BS = 16;

  logic            clkIn = 1'b0;
  logic            resetIn;
  logic [7:0]      ramDataIn, ramDataOut;
  logic [AW-1:0]   ramAddr;
  logic            ramWr;
  logic            icacheMiss, fetchAbort;
  logic [AW-BW-1:0] icacheAddr;
  logic            refillValid;
  logic [AW-BW-1:0] refillAddr;
  logic [BS*8-1:0] refillData;
  logic            dataReq, dataWrite;
  logic [AW-1:0]   dataAddr;
  logic [1:0]      dataSize;
  logic [31:0]     dataIn;
  logic            dataDone;
  logic [31:0]     dataOut;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .BLOCK_SIZE(BS)) dut (
    .clkIn(clkIn), .resetIn(resetIn),
    .ramDataIn(ramDataIn), .ramDataOut(ramDataOut), .ramAddr(ramAddr), .ramWr(ramWr),
    .icacheMiss(icacheMiss), .icacheAddr(icacheAddr), .fetchAbort(fetchAbort),
    .refillValid(refillValid), .refillAddr(refillAddr), .refillData(refillData),
    .dataReq(dataReq), .dataWrite(dataWrite), .dataAddr(dataAddr), .dataSize(dataSize),
    .dataIn(dataIn), .dataDone(dataDone), .dataOut(dataOut)
  );

  always #5 clkIn = ~clkIn;

  // Initial RAM contents: a few hand-placed bytes, a fixed pattern elsewhere.
  function automatic logic [7:0] init(input int a);
    case (a)
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h33;
      32'h103: return 8'h44;
      32'h204: return 8'h5A;
      32'h402: return 8'h77;
      32'h403: return 8'h88;
      default: return 8'((a * 13) ^ (a >> 5));
    endcase
  endfunction

  function automatic logic [BS*8-1:0] blockOf(input int blk);
    logic [BS*8-1:0] r;
    for (int i = 0; i < BS; i++) r[i*8 +: 8] = init(blk * BS + i);
    return r;
  endfunction

  // RAM model: contents loaded on the first edge, registered read.
  logic [7:0] ram [0:2**AW-1];
  logic       ramLoaded = 1'b0;
  logic [7:0] ramQ = 8'h00;
  always @(posedge clkIn) begin
    if (!ramLoaded) begin
      for (int i = 0; i < 2**AW; i++) ram[i] <= init(i);
      ramLoaded <= 1'b1;
    end else if (ramWr) begin
      ram[ramAddr] <= ramDataOut;
    end
    ramQ <= ram[ramAddr];
  end
  assign ramDataIn = ramQ;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clkIn);
      #1;
    end
  endtask

  task automatic test_reset();
    resetIn = 1'b0; icacheMiss = 1'b0; fetchAbort = 1'b0; icacheAddr = '0;
    dataReq = 1'b0; dataWrite = 1'b0; dataAddr = '0; dataSize = 2'b00; dataIn = '0;
    tick(3);
    checks++;
    if ({ramWr, ramAddr, ramDataOut, refillValid, refillAddr, dataDone, dataOut} !== '0 || refillData !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%b addr=%h do=%h rv=%b ra=%h dd=%b dout=%h expected all 0",
               ramWr, ramAddr, ramDataOut, refillValid, refillAddr, dataDone, dataOut);
    end
    resetIn = 1'b1;
    tick();
    checks++;
    if (ramAddr !== '0 || ramWr !== 1'b0 || dataDone !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got addr=%h wr=%b dd=%b expected 0 0 0", ramAddr, ramWr, dataDone);
    end
  endtask

  task automatic test_word_load();
    dataReq = 1'b1; dataWrite = 1'b0; dataAddr = 17'h00100; dataSize = 2'b10;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (ramAddr !== 17'(32'h100 + k) || ramWr !== 1'b0 || dataDone !== 1'b0) begin
        errors++;
        $display("FAIL load_addr[%0d]: got addr=%h wr=%b dd=%b expected addr=%h wr=0 dd=0",
                 k, ramAddr, ramWr, dataDone, 17'(32'h100 + k));
      end
    end
    tick();
    checks++;
    if (ramAddr !== '0 || dataDone !== 1'b0) begin
      errors++;
      $display("FAIL load_capture_cycle: got addr=%h dd=%b expected 0 0", ramAddr, dataDone);
    end
    tick();
    checks++;
    if (dataDone !== 1'b1 || dataOut !== 32'h44332211) begin
      errors++;
      $display("FAIL load_word_done: got dd=%b dout=%h expected 1 44332211", dataDone, dataOut);
    end
    // Request still held through the done cycle: must not be served again.
    tick();
    checks++;
    if (dataDone !== 1'b0 || ramAddr !== '0) begin
      errors++;
      $display("FAIL no_double_service: got dd=%b addr=%h expected 0 0", dataDone, ramAddr);
    end
    dataReq = 1'b0;
    tick(2);
    checks++;
    if (dataDone !== 1'b0 || dataOut !== 32'h44332211) begin
      errors++;
      $display("FAIL load_hold: got dd=%b dout=%h expected 0 44332211", dataDone, dataOut);
    end
  endtask

  task automatic test_byte_store();
    dataReq = 1'b1; dataWrite = 1'b1; dataAddr = 17'h00203; dataSize = 2'b00; dataIn = 32'hDEADBEEF;
    tick();
    checks++;
    if (ramWr !== 1'b1 || ramAddr !== 17'h00203 || ramDataOut !== 8'hEF || dataDone !== 1'b0) begin
      errors++;
      $display("FAIL store_byte_write: got wr=%b addr=%h do=%h dd=%b expected 1 00203 ef 0",
               ramWr, ramAddr, ramDataOut, dataDone);
    end
    tick();
    checks++;
    if (ramWr !== 1'b0 || ramAddr !== '0 || ramDataOut !== '0 || dataDone !== 1'b0) begin
      errors++;
      $display("FAIL store_byte_final: got wr=%b addr=%h do=%h dd=%b expected 0 0 0 0",
               ramWr, ramAddr, ramDataOut, dataDone);
    end
    tick();
    checks++;
    if (dataDone !== 1'b1 || ramWr !== 1'b0) begin
      errors++;
      $display("FAIL store_byte_done: got dd=%b wr=%b expected 1 0", dataDone, ramWr);
    end
    dataReq = 1'b0;
    tick();
    checks++;
    if (dataDone !== 1'b0 || ram[17'h203] !== 8'hEF || ram[17'h204] !== 8'h5A || dataOut !== 32'h44332211) begin
      errors++;
      $display("FAIL store_byte_ram: got dd=%b m203=%h m204=%h dout=%h expected 0 ef 5a 44332211",
               dataDone, ram[17'h203], ram[17'h204], dataOut);
    end
  endtask

  task automatic test_wrap_store();
    logic [31:0] d;
    d = 32'h87654321;
    dataReq = 1'b1; dataWrite = 1'b1; dataAddr = 17'h1FFFE; dataSize = 2'b11; dataIn = d;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (ramWr !== 1'b1 || ramAddr !== 17'(32'h1FFFE + k) || ramDataOut !== d[k*8 +: 8]) begin
        errors++;
        $display("FAIL wrap_store[%0d]: got wr=%b addr=%h do=%h expected 1 %h %h",
                 k, ramWr, ramAddr, ramDataOut, 17'(32'h1FFFE + k), d[k*8 +: 8]);
      end
    end
    tick();
    checks++;
    if (ramWr !== 1'b0 || dataDone !== 1'b0) begin
      errors++;
      $display("FAIL wrap_store_final: got wr=%b dd=%b expected 0 0", ramWr, dataDone);
    end
    tick();
    checks++;
    if (dataDone !== 1'b1) begin
      errors++;
      $display("FAIL wrap_store_done: got dd=%b expected 1", dataDone);
    end
    dataReq = 1'b0;
    tick();
    checks++;
    if ({ram[17'h00001], ram[17'h00000], ram[17'h1FFFF], ram[17'h1FFFE]} !== d) begin
      errors++;
      $display("FAIL wrap_store_ram: got %h expected %h",
               {ram[17'h00001], ram[17'h00000], ram[17'h1FFFF], ram[17'h1FFFE]}, d);
    end
  endtask

  task automatic test_priority(output logic [BS*8-1:0] delivered);
    logic [BS*8-1:0] expBlk;
    expBlk = blockOf(32'h012);
    dataReq = 1'b1; dataWrite = 1'b0; dataAddr = 17'h00010; dataSize = 2'b01;
    icacheMiss = 1'b1; icacheAddr = 13'h012;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (ramAddr !== 17'(32'h10 + k)) begin
        errors++;
        $display("FAIL prio_load_addr[%0d]: got %h expected %h", k, ramAddr, 17'(32'h10 + k));
      end
    end
    tick(2);
    checks++;
    if (dataDone !== 1'b1 || dataOut !== {16'h0000, init(32'h11), init(32'h10)}) begin
      errors++;
      $display("FAIL prio_half_load: got dd=%b dout=%h expected 1 %h",
               dataDone, dataOut, {16'h0000, init(32'h11), init(32'h10)});
    end
    dataReq = 1'b0;
    // Fetch is accepted on the dataDone cycle.
    for (int k = 0; k < BS; k++) begin
      tick();
      checks++;
      if (ramAddr !== 17'(32'h120 + k) || refillValid !== 1'b0) begin
        errors++;
        $display("FAIL fetch_addr[%0d]: got addr=%h rv=%b expected %h 0",
                 k, ramAddr, refillValid, 17'(32'h120 + k));
      end
    end
    tick();
    checks++;
    if (ramAddr !== '0 || refillValid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_capture_cycle: got addr=%h rv=%b expected 0 0", ramAddr, refillValid);
    end
    tick();
    checks++;
    if (refillValid !== 1'b1 || refillAddr !== 13'h012 || refillData !== expBlk) begin
      errors++;
      $display("FAIL refill: got rv=%b ra=%h data=%h expected 1 012 %h",
               refillValid, refillAddr, refillData, expBlk);
    end
    // icacheMiss still high during the refillValid cycle: no re-accept.
    tick();
    checks++;
    if (refillValid !== 1'b0 || ramAddr !== '0) begin
      errors++;
      $display("FAIL refill_no_double: got rv=%b addr=%h expected 0 0", refillValid, ramAddr);
    end
    icacheMiss = 1'b0;
    tick();
    checks++;
    if (refillData !== expBlk || refillAddr !== 13'h012) begin
      errors++;
      $display("FAIL refill_hold: got ra=%h data=%h expected 012 %h", refillAddr, refillData, expBlk);
    end
    delivered = expBlk;
  endtask

  task automatic test_abort(input logic [BS*8-1:0] prev);
    logic [BS*8-1:0] expBlk;
    expBlk = blockOf(32'h034);
    icacheMiss = 1'b1; icacheAddr = 13'h034;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (ramAddr !== 17'(32'h340 + k)) begin
        errors++;
        $display("FAIL abort_pre[%0d]: got %h expected %h", k, ramAddr, 17'(32'h340 + k));
      end
    end
    fetchAbort = 1'b1;
    tick();
    checks++;
    if (ramAddr !== '0 || refillValid !== 1'b0 || refillData !== prev) begin
      errors++;
      $display("FAIL abort_idle: got addr=%h rv=%b data=%h expected 0 0 %h", ramAddr, refillValid, refillData, prev);
    end
    fetchAbort = 1'b0;
    for (int k = 0; k < BS; k++) begin
      tick();
      checks++;
      if (ramAddr !== 17'(32'h340 + k) || refillValid !== 1'b0) begin
        errors++;
        $display("FAIL refetch_addr[%0d]: got addr=%h rv=%b expected %h 0",
                 k, ramAddr, refillValid, 17'(32'h340 + k));
      end
    end
    tick(2);
    checks++;
    if (refillValid !== 1'b1 || refillAddr !== 13'h034 || refillData !== expBlk) begin
      errors++;
      $display("FAIL refetch_refill: got rv=%b ra=%h data=%h expected 1 034 %h",
               refillValid, refillAddr, refillData, expBlk);
    end
    icacheMiss = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_store();
    dataReq = 1'b1; dataWrite = 1'b1; dataAddr = 17'h00400; dataSize = 2'b10; dataIn = 32'hA1B2C3D4;
    tick(3);
    checks++;
    if (ramWr !== 1'b1 || ramAddr !== 17'h00402) begin
      errors++;
      $display("FAIL pre_reset_store: got wr=%b addr=%h expected 1 00402", ramWr, ramAddr);
    end
    #2;
    resetIn = 1'b0;
    #1;
    checks++;
    if ({ramWr, ramAddr, ramDataOut, refillValid, refillAddr, dataDone, dataOut} !== '0 || refillData !== '0) begin
      errors++;
      $display("FAIL async_reset: got wr=%b addr=%h do=%h rv=%b ra=%h dd=%b dout=%h expected all 0",
               ramWr, ramAddr, ramDataOut, refillValid, refillAddr, dataDone, dataOut);
    end
    dataReq = 1'b0;
    tick();
    resetIn = 1'b1;
    tick();
    checks++;
    if (dataDone !== 1'b0 || ramWr !== 1'b0 ||
        {ram[17'h403], ram[17'h402], ram[17'h401], ram[17'h400]} !== 32'h8877C3D4) begin
      errors++;
      $display("FAIL reset_abandon: got dd=%b wr=%b ram=%h expected 0 0 8877c3d4", dataDone, ramWr,
               {ram[17'h403], ram[17'h402], ram[17'h401], ram[17'h400]});
    end
    dataReq = 1'b1; dataWrite = 1'b0; dataAddr = 17'h00401; dataSize = 2'b00;
    tick();
    checks++;
    if (ramAddr !== 17'h00401) begin
      errors++;
      $display("FAIL post_reset_addr: got %h expected 00401", ramAddr);
    end
    tick(2);
    checks++;
    if (dataDone !== 1'b1 || dataOut !== 32'h000000C3) begin
      errors++;
      $display("FAIL post_reset_load: got dd=%b dout=%h expected 1 000000c3", dataDone, dataOut);
    end
    dataReq = 1'b0;
    tick();
  endtask

  initial begin
    logic [BS*8-1:0] lastBlk;
    test_reset();
    test_word_load();
    test_byte_store();
    test_wrap_store();
    test_priority(lastBlk);
    test_abort(lastBlk);
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
